// File: rtl/handshake_pkg.sv
// Shared types and constants for the constant-match handshake block.
// Optional mismatch counter is enabled with CONST_MATCH_CNT_EN.
package handshake_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int MISMATCH_CNT_W = 16;

    // Saturating increment used by the optional mismatch counter.
    function automatic logic [MISMATCH_CNT_W-1:0] sat_inc(input logic [MISMATCH_CNT_W-1:0] val);
        if (val == {MISMATCH_CNT_W{1'b1}}) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/handshake_flag_fifo2.sv
// Two-entry, one-bit-wide FIFO with registered occupancy state and 1-bit ring pointers.
module handshake_flag_fifo2
    import handshake_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    occ_t       state_q, state_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] mem_q, mem_d;
    logic       push_ok;
    logic       pop_ok;

    assign push_ok = push && (state_q != OCC_FULL);
    assign pop_ok  = pop && (state_q != OCC_EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push_ok) begin
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_ok && !pop_ok) begin
                    state_d = OCC_FULL;
                end else if (pop_ok && !push_ok) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop_ok) begin
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // Pointers wrap naturally 1->0 as single bits.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_comb begin
        empty = (state_q == OCC_EMPTY);
        full  = (state_q == OCC_FULL);
        dout  = mem_q[rd_ptr_q] && (state_q != OCC_EMPTY);
    end

endmodule

// File: rtl/handshake_const_match.sv
// Compares each accepted data token against CONST_VALUE and emits a buffered match flag.
// Define CONST_MATCH_CNT_EN to add a saturating mismatch_count output.
module handshake_const_match
    import handshake_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int unsigned CONST_VALUE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_match
`ifdef CONST_MATCH_CNT_EN
    ,
    output logic [MISMATCH_CNT_W-1:0] mismatch_count
`endif
);

    localparam logic [DATA_WIDTH-1:0] CONST_CMP = DATA_WIDTH'(CONST_VALUE);

    logic push;
    logic pop;
    logic ins_match;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_dout;

    // Handshake signals come from registered occupancy only, so no comb path crosses the block.
    assign ins_ready  = !fifo_full;
    assign outs_valid = !fifo_empty;
    assign outs_match = fifo_dout;

    assign push      = ins_valid && ins_ready;
    assign pop       = outs_valid && outs_ready;
    assign ins_match = (ins == CONST_CMP);

    handshake_flag_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ins_match),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CONST_MATCH_CNT_EN
    logic [MISMATCH_CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch_cnt_q <= '0;
        end else begin
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    always_comb begin
        mismatch_cnt_d = mismatch_cnt_q;
        if (push && !ins_match) begin
            mismatch_cnt_d = sat_inc(mismatch_cnt_q);
        end
    end

    assign mismatch_count = mismatch_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_const_match.sv
// Self-checking bench for handshake_const_match: vector table, scoreboard and corner sequences.
// Exercises the mismatch counter as well when CONST_MATCH_CNT_EN is defined.
module tb_handshake_const_match;

    localparam int          DW = 32;
    localparam int unsigned CV = 1000;

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          e_irdy;
        logic          e_ov;
        logic          e_match;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          outs_valid;
    logic          outs_ready;
    logic          outs_match;
`ifdef CONST_MATCH_CNT_EN
    logic [15:0]   mismatch_count;
    int unsigned   exp_cnt;
`endif

    int   total;
    int   bad;
    logic sb_q[$];
    vec_t vecs[$];

    handshake_const_match #(
        .DATA_WIDTH  (DW),
        .CONST_VALUE (CV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready),
        .outs_match (outs_match)
`ifdef CONST_MATCH_CNT_EN
        ,
        .mismatch_count (mismatch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic iv, input logic [DW-1:0] din, input logic ordy,
                          input logic e_irdy, input logic e_ov, input logic e_match);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_match = e_match;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs at the falling edge and score the transfers the next rising edge takes.
    task automatic applyStimulus(input logic iv, input logic [DW-1:0] din, input logic ordy);
        logic exp_m;
        @(negedge clk);
        ins_valid  = iv;
        ins        = din;
        outs_ready = ordy;
        #1;
        if (rst) begin
`ifdef CONST_MATCH_CNT_EN
            compareVal("mismatch_count_track", {16'd0, mismatch_count}, exp_cnt);
            if (ins_valid && ins_ready && (ins !== CV) && exp_cnt != 32'hFFFF) exp_cnt++;
`endif
            if (outs_valid && outs_ready) begin
                if (sb_q.size() == 0) begin
                    compareVal("sb_spurious_output", 32'd1, 32'd0);
                end else begin
                    exp_m = sb_q.pop_front();
                    compareVal("sb_outs_match", {31'd0, outs_match}, {31'd0, exp_m});
                end
            end
            if (ins_valid && ins_ready) sb_q.push_back(ins == CV);
        end
    endtask

    task automatic checkOutput(input string name, input logic e_irdy, input logic e_ov, input logic e_match);
        compareVal({name, "_ins_ready"}, {31'd0, ins_ready}, {31'd0, e_irdy});
        compareVal({name, "_outs_valid"}, {31'd0, outs_valid}, {31'd0, e_ov});
        if (e_ov) compareVal({name, "_outs_match"}, {31'd0, outs_match}, {31'd0, e_match});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b0;
        ins        = '0;
        ins_valid  = 1'b0;
        outs_ready = 1'b0;
`ifdef CONST_MATCH_CNT_EN
        exp_cnt = 0;
`endif

        // single token
        addVec(1, 1000, 1, 1, 0, 0);
        addVec(0,    0, 1, 1, 1, 1);
        addVec(0,    0, 1, 1, 0, 0);
        // back-to-back stream
        addVec(1, 1000, 1, 1, 0, 0);
        addVec(1,    7, 1, 1, 1, 1);
        addVec(1, 1000, 1, 1, 1, 0);
        addVec(0,    0, 1, 1, 1, 1);
        addVec(0,    0, 1, 1, 0, 0);
        // back-pressure fills the buffer
        addVec(1,    5, 0, 1, 0, 0);
        addVec(1, 1000, 0, 1, 1, 0);
        addVec(1,   42, 0, 0, 1, 0);
        addVec(1,   42, 0, 0, 1, 0);
        addVec(0,    0, 1, 0, 1, 0);
        addVec(0,    0, 1, 1, 1, 1);
        addVec(0,    0, 1, 1, 0, 0);
        // FULL with valid and ready together: pop only
        addVec(1, 1000, 0, 1, 0, 0);
        addVec(1,    3, 0, 1, 1, 1);
        addVec(1, 1000, 1, 0, 1, 1);
        addVec(1, 1000, 0, 1, 1, 0);
        addVec(0,    0, 1, 0, 1, 0);
        addVec(0,    0, 1, 1, 1, 1);
        addVec(0,    0, 0, 1, 0, 0);
        // X on ins while not valid
        addVec(0, 'x,   1, 1, 0, 0);
        addVec(0, 1000, 1, 1, 0, 0);
        addVec(1, 1000, 0, 1, 0, 0);
        addVec(0, 'x,   0, 1, 1, 1);
        addVec(0, 'x,   1, 1, 1, 1);
        addVec(0, 'x,   1, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        compareVal("reset_ins_ready", {31'd0, ins_ready}, 32'd1);
        compareVal("reset_outs_valid", {31'd0, outs_valid}, 32'd0);
        compareVal("reset_outs_match", {31'd0, outs_match}, 32'd0);
`ifdef CONST_MATCH_CNT_EN
        compareVal("reset_mismatch_count", {16'd0, mismatch_count}, 32'd0);
`endif
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].iv, vecs[i].din, vecs[i].ordy);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_match);
        end

        // Reset while two tokens are buffered.
        applyStimulus(1, 1000, 0); checkOutput("mid_rst_a", 1, 0, 0);
        applyStimulus(1,    9, 0); checkOutput("mid_rst_b", 1, 1, 1);
        applyStimulus(0,    0, 0); checkOutput("mid_rst_c", 0, 1, 1);
        #1;
        rst = 1'b0;
        #1;
        compareVal("async_rst_outs_valid", {31'd0, outs_valid}, 32'd0);
        compareVal("async_rst_ins_ready", {31'd0, ins_ready}, 32'd1);
        compareVal("async_rst_outs_match", {31'd0, outs_match}, 32'd0);
        sb_q.delete();
`ifdef CONST_MATCH_CNT_EN
        exp_cnt = 0;
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1);
            checkOutput($sformatf("post_rst_idle%0d", i), 1, 0, 0);
        end
        applyStimulus(1, 1000, 1); checkOutput("post_rst_tok_a", 1, 0, 0);
        applyStimulus(0,    0, 1); checkOutput("post_rst_tok_b", 1, 1, 1);
        applyStimulus(0,    0, 1); checkOutput("post_rst_tok_c", 1, 0, 0);

`ifdef CONST_MATCH_CNT_EN
        #1;
        rst = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 7, 1);
        applyStimulus(1, 1000, 1);
        applyStimulus(1, 8, 1);
        applyStimulus(1, 9, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        compareVal("mismatch_count_three", {16'd0, mismatch_count}, 32'd3);
        // Drive enough mismatches to hit saturation and keep going past it.
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1, 32'd1, 1);
        end
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        compareVal("mismatch_count_saturated", {16'd0, mismatch_count}, 32'hFFFF);
`endif

        compareVal("sb_drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
